// File: rtl/axil_arbiter_rd_if.sv
// -----------------------------------------------------------------------------
// axil_arbiter_rd_if
//
// Bundle of request/handshake and grant signals around the AXI-Lite read-path
// arbiter.
//
//   m_axil_arvalid  [NUMBER_MASTER]      ARVALID of each master, bit i = master i
//   s_axil_arready                       ARREADY from the muxed slave side
//   s_axil_rvalid                        RVALID from the muxed slave side
//   s_axil_rready                        RREADY of the granted master (muxed)
//   grant           [NUMBER_MASTER]      one-hot grant (registered)
//   grant_idx       [$clog2(NUMBER_MASTER)] binary index of the granted master
//   grant_valid                          high while any grant is held
//   timeout_err                          watchdog pulse (AXIL_ARB_TIMEOUT_EN only)
//
// Modports:
//   slave  - the arbiter: samples requests/handshakes, drives the grant side
//   master - the requesting/interconnect side: drives requests, observes grant
//
// Optional feature macro: AXIL_ARB_TIMEOUT_EN (adds timeout_err).
// -----------------------------------------------------------------------------
interface axil_arbiter_rd_if #(
  parameter int unsigned NUMBER_MASTER = 4
);
  localparam int unsigned IDX_W = $clog2(NUMBER_MASTER);

  logic [NUMBER_MASTER-1:0] m_axil_arvalid;
  logic                     s_axil_arready;
  logic                     s_axil_rvalid;
  logic                     s_axil_rready;
  logic [NUMBER_MASTER-1:0] grant;
  logic [IDX_W-1:0]         grant_idx;
  logic                     grant_valid;
`ifdef AXIL_ARB_TIMEOUT_EN
  logic                     timeout_err;
`endif

  modport slave (
    input  m_axil_arvalid,
    input  s_axil_arready,
    input  s_axil_rvalid,
    input  s_axil_rready,
    output grant,
    output grant_idx,
`ifdef AXIL_ARB_TIMEOUT_EN
    output timeout_err,
`endif
    output grant_valid
  );

  modport master (
    output m_axil_arvalid,
    output s_axil_arready,
    output s_axil_rvalid,
    output s_axil_rready,
    input  grant,
    input  grant_idx,
`ifdef AXIL_ARB_TIMEOUT_EN
    input  timeout_err,
`endif
    input  grant_valid
  );

endinterface

// File: rtl/axil_arbiter_rd.sv
// -----------------------------------------------------------------------------
// axil_arbiter_rd
//
// Fixed-priority arbiter for the AXI-Lite read path. Picks the lowest-index
// master asserting ARVALID and holds the grant for the whole read transaction
// (AR handshake, then R handshake). Master 0 has the highest priority. There
// is no preemption; after every transaction at least one cycle is spent in
// IDLE with the grant dropped.
//
// Ports:
//   aclk     in  clock, all logic on posedge
//   aresetn  in  asynchronous active-low reset (clears grant immediately)
//   bus      axil_arbiter_rd_if.slave:
//              m_axil_arvalid, s_axil_arready, s_axil_rvalid, s_axil_rready in;
//              grant, grant_idx, grant_valid (and timeout_err) out, all registered
//
// Parameters:
//   NUMBER_MASTER   number of requesting masters (>=2)
//   TIMEOUT_CYCLES  DATA-state watchdog limit (>=2), present only with the macro
//
// Optional feature macro: AXIL_ARB_TIMEOUT_EN
//   Adds a watchdog in DATA: after TIMEOUT_CYCLES cycles without an R handshake
//   the grant is dropped and timeout_err pulses for one cycle. An R handshake
//   on the expiry cycle wins and exits normally.
// -----------------------------------------------------------------------------
module axil_arbiter_rd #(
  parameter int unsigned NUMBER_MASTER  = 4
`ifdef AXIL_ARB_TIMEOUT_EN
 ,parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
  input  logic               aclk,
  input  logic               aresetn,
  axil_arbiter_rd_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(NUMBER_MASTER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [NUMBER_MASTER-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     gv_q, gv_d;

  // Priority encoder result for the IDLE decision
  logic                     req_found;
  logic [IDX_W-1:0]         req_idx;

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     tmo_q, tmo_d;
`endif

  // Lowest set index wins; the found flag stops later (lower-priority) bits
  // from overwriting the first hit.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    for (int unsigned i = 0; i < NUMBER_MASTER; i++) begin
      if (bus.m_axil_arvalid[i] && !req_found) begin
        req_found = 1'b1;
        req_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
`ifdef AXIL_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req_found) begin
          grant_d          = '0;
          grant_d[req_idx] = 1'b1;
          idx_d            = req_idx;
          state_d          = ADDR;
        end
      end

      ADDR: begin
        // A dropped ARVALID keeps the grant; an early R handshake is ignored.
        if (bus.m_axil_arvalid[idx_q] && bus.s_axil_arready) begin
          state_d = DATA;
`ifdef AXIL_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      DATA: begin
        if (bus.s_axil_rvalid && bus.s_axil_rready) begin
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
        end
`ifdef AXIL_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
`endif
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase

    gv_d = |grant_d;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      gv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      gv_q    <= gv_d;
    end
  end

`ifdef AXIL_ARB_TIMEOUT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign bus.timeout_err = tmo_q;
`endif

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = gv_q;

endmodule

// File: tb/tb_axil_arbiter_rd.sv
module tb_axil_arbiter_rd;

  logic aclk;
  logic aresetn;

  int unsigned n_vec;
  int unsigned n_miss;

  axil_arbiter_rd_if #(.NUMBER_MASTER(4)) bus ();

`ifdef AXIL_ARB_TIMEOUT_EN
  axil_arbiter_rd #(.NUMBER_MASTER(4), .TIMEOUT_CYCLES(8)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus.slave)
  );
`else
  axil_arbiter_rd #(.NUMBER_MASTER(4)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus.slave)
  );
`endif

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] idx);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".gv"}, 32'(bus.grant_valid), 32'(|g));
    if (g != 4'b0000) chk({tag, ".idx"}, 32'(bus.grant_idx), 32'(idx));
  endtask

  task automatic idle_inputs();
    bus.m_axil_arvalid = 4'b0000;
    bus.s_axil_arready = 1'b0;
    bus.s_axil_rvalid  = 1'b0;
    bus.s_axil_rready  = 1'b0;
  endtask

  task automatic set_r(input logic v);
    bus.s_axil_rvalid = v;
    bus.s_axil_rready = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    idle_inputs();
    aresetn = 1'b0;

    // 1. Reset held with all masters requesting
    bus.m_axil_arvalid = 4'b1111;
    #1;
    chk_grant("rst0", 4'b0000, 2'd0);
    chk("rst0.idx", 32'(bus.grant_idx), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_grant("rst_hold", 4'b0000, 2'd0);
    end
    bus.m_axil_arvalid = 4'b0000;
    aresetn = 1'b1;
    tick();
    chk_grant("rst_rel", 4'b0000, 2'd0);

    // 2. Single request, with ARVALID drop and early R handshake in ADDR
    bus.m_axil_arvalid = 4'b0100;
    tick();
    chk_grant("single.gnt", 4'b0100, 2'd2);
    bus.m_axil_arvalid = 4'b0000;
    bus.s_axil_arready = 1'b1;
    tick();
    chk_grant("single.ardrop", 4'b0100, 2'd2);
    bus.s_axil_arready = 1'b0;
    set_r(1'b1);
    tick();
    chk_grant("single.early_r", 4'b0100, 2'd2);
    set_r(1'b0);
    bus.m_axil_arvalid = 4'b0100;
    bus.s_axil_arready = 1'b1;
    tick();
    chk_grant("single.data", 4'b0100, 2'd2);
    idle_inputs();
    tick();
    chk_grant("single.data_wait", 4'b0100, 2'd2);
    set_r(1'b1);
    tick();
    chk_grant("single.done", 4'b0000, 2'd0);
    set_r(1'b0);
    tick();
    chk_grant("single.idle", 4'b0000, 2'd0);

    // 3. Contention: master 1 beats master 3, then master 3 after one IDLE cycle
    bus.m_axil_arvalid = 4'b1010;
    tick();
    chk_grant("cont.gnt1", 4'b0010, 2'd1);
    bus.s_axil_arready = 1'b1;
    tick();
    chk_grant("cont.data1", 4'b0010, 2'd1);
    bus.m_axil_arvalid = 4'b1000;
    bus.s_axil_arready = 1'b0;
    set_r(1'b1);
    tick();
    chk_grant("cont.idle", 4'b0000, 2'd0);
    set_r(1'b0);
    tick();
    chk_grant("cont.gnt3", 4'b1000, 2'd3);
    bus.s_axil_arready = 1'b1;
    tick();
    idle_inputs();
    set_r(1'b1);
    tick();
    chk_grant("cont.done3", 4'b0000, 2'd0);
    idle_inputs();
    tick();

    // 4. No preemption by master 0 while master 2 is in DATA
    bus.m_axil_arvalid = 4'b0100;
    tick();
    bus.s_axil_arready = 1'b1;
    tick();
    bus.m_axil_arvalid = 4'b0001;
    tick();
    chk_grant("nopre.a", 4'b0100, 2'd2);
    tick();
    chk_grant("nopre.b", 4'b0100, 2'd2);
    bus.s_axil_arready = 1'b0;
    set_r(1'b1);
    tick();
    chk_grant("nopre.done", 4'b0000, 2'd0);
    set_r(1'b0);
    tick();
    chk_grant("nopre.gnt0", 4'b0001, 2'd0);
    bus.s_axil_arready = 1'b1;
    tick();
    idle_inputs();
    set_r(1'b1);
    tick();
    idle_inputs();
    tick();

    // 5. Back-to-back AR then R handshake, immediate re-request
    bus.m_axil_arvalid = 4'b0010;
    tick();
    chk_grant("b2b.gnt", 4'b0010, 2'd1);
    bus.s_axil_arready = 1'b1;
    tick();
    bus.s_axil_arready = 1'b0;
    set_r(1'b1);
    tick();
    chk_grant("b2b.idle", 4'b0000, 2'd0);
    set_r(1'b0);
    tick();
    chk_grant("b2b.regnt", 4'b0010, 2'd1);
    bus.s_axil_arready = 1'b1;
    tick();
    idle_inputs();
    set_r(1'b1);
    tick();
    idle_inputs();
    tick();

`ifdef AXIL_ARB_TIMEOUT_EN
    // 6a. Watchdog expiry after 8 DATA cycles
    chk("tmo.idle", 32'(bus.timeout_err), 32'd0);
    bus.m_axil_arvalid = 4'b0001;
    tick();
    bus.s_axil_arready = 1'b1;
    tick();
    idle_inputs();
    for (int k = 0; k < 7; k++) begin
      chk_grant("tmo.hold", 4'b0001, 2'd0);
      chk("tmo.nopulse", 32'(bus.timeout_err), 32'd0);
      tick();
    end
    chk_grant("tmo.last", 4'b0001, 2'd0);
    tick();
    chk_grant("tmo.drop", 4'b0000, 2'd0);
    chk("tmo.pulse", 32'(bus.timeout_err), 32'd1);
    tick();
    chk("tmo.pulse_end", 32'(bus.timeout_err), 32'd0);

    // 6b. R handshake on the expiry cycle wins
    bus.m_axil_arvalid = 4'b0100;
    tick();
    bus.s_axil_arready = 1'b1;
    tick();
    idle_inputs();
    for (int k = 0; k < 7; k++) tick();
    chk_grant("tmo2.last", 4'b0100, 2'd2);
    set_r(1'b1);
    tick();
    chk_grant("tmo2.done", 4'b0000, 2'd0);
    chk("tmo2.nopulse", 32'(bus.timeout_err), 32'd0);
    idle_inputs();
    tick();
    chk("tmo2.after", 32'(bus.timeout_err), 32'd0);
`else
    // 6. Without the watchdog DATA waits indefinitely
    bus.m_axil_arvalid = 4'b0001;
    tick();
    bus.s_axil_arready = 1'b1;
    tick();
    idle_inputs();
    for (int k = 0; k < 20; k++) tick();
    chk_grant("nowd.hold", 4'b0001, 2'd0);
    set_r(1'b1);
    tick();
    chk_grant("nowd.done", 4'b0000, 2'd0);
    idle_inputs();
    tick();
`endif

    // 1b. Asynchronous reset in the middle of DATA
    bus.m_axil_arvalid = 4'b1000;
    tick();
    bus.s_axil_arready = 1'b1;
    tick();
    idle_inputs();
    chk_grant("arst.pre", 4'b1000, 2'd3);
    #2;
    aresetn = 1'b0;
    #1;
    chk_grant("arst.async", 4'b0000, 2'd0);
    chk("arst.idx", 32'(bus.grant_idx), 32'd0);
    tick();
    aresetn = 1'b1;
    tick();
    chk_grant("arst.after", 4'b0000, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
